// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared widths, sequencer state encoding and bus helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 16;
    localparam int ZEXT_W  = DATA_W - ADDR_W;
    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 2'd0,
        ST_HOLD   = 2'd1,
        ST_JUMP   = 2'd2,
        ST_HALTED = 2'd3
    } seq_state_e;

    // Widen a PC-sized address to bus width with zero fill.
    function automatic logic [DATA_W-1:0] zext_addr(input logic [ADDR_W-1:0] addr);
        return {{ZEXT_W{1'b0}}, addr};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer_if
//  Description : PC, instruction-memory, decode and bus signals of the sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W
);
    logic [ADDR_W-1:0] pc_in;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] ir_out;
    logic              ir_valid;
    logic              dec_ready;
    logic              jump_req;
    logic [ADDR_W-1:0] jump_target;
    logic              halt_req;
    logic              pcinc;
    logic              pcload;
    logic [DATA_W-1:0] bus_out;
    logic              bus_en;
    logic              halted;

    // Sequencer side.
    modport master (
        input  pc_in, mem_ready, mem_data, dec_ready, jump_req, jump_target, halt_req,
        output mem_addr, mem_rd, ir_out, ir_valid, pcinc, pcload, bus_out, bus_en, halted
    );

    // PC / memory / decode side.
    modport slave (
        output pc_in, mem_ready, mem_data, dec_ready, jump_req, jump_target, halt_req,
        input  mem_addr, mem_rd, ir_out, ir_valid, pcinc, pcload, bus_out, bus_en, halted
    );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Fetches from instruction memory at the PC, holds the word for
//                decode and drives PC increment / jump-load strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import cpu_pkg::*;
(
    input  wire logic         clk,
    input  wire logic         rst_n,
    fetch_sequencer_if.master bus
);

    seq_state_e        state_q,    state_d;
    logic [DATA_W-1:0] ir_q,       ir_d;
    logic [DATA_W-1:0] bus_out_q,  bus_out_d;
    logic              mem_rd_q,   mem_rd_d;
    logic              ir_valid_q, ir_valid_d;
    logic              pcinc_q,    pcinc_d;
    logic              pcload_q,   pcload_d;
    logic              halted_q,   halted_d;

    logic capture;
    logic accept;

    // mem_rd_q gates capture so a ready seen in the first cycle after reset,
    // before any request went out, is not taken.
    assign capture = (state_q == ST_FETCH) && mem_rd_q && bus.mem_ready;
    assign accept  = (state_q == ST_HOLD) && bus.dec_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            ir_q       <= '0;
            bus_out_q  <= '0;
            mem_rd_q   <= 1'b0;
            ir_valid_q <= 1'b0;
            pcinc_q    <= 1'b0;
            pcload_q   <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            bus_out_q  <= bus_out_d;
            mem_rd_q   <= mem_rd_d;
            ir_valid_q <= ir_valid_d;
            pcinc_q    <= pcinc_d;
            pcload_q   <= pcload_d;
            halted_q   <= halted_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FETCH:  if (capture) state_d = ST_HOLD;
            ST_HOLD: begin
                if (accept) begin
                    if (bus.halt_req)      state_d = ST_HALTED;
                    else if (bus.jump_req) state_d = ST_JUMP;
                    else                   state_d = ST_FETCH;
                end
            end
            ST_JUMP:   state_d = ST_FETCH;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_FETCH;
        endcase
    end

    // Strobes are registered from the upcoming state so they line up with it.
    always_comb begin
        ir_d       = capture ? bus.mem_data : ir_q;
        mem_rd_d   = (state_d == ST_FETCH);
        ir_valid_d = (state_d == ST_HOLD);
        pcinc_d    = capture;
        pcload_d   = (state_d == ST_JUMP);
        bus_out_d  = (state_d == ST_JUMP) ? zext_addr(bus.jump_target) : '0;
        halted_d   = (state_d == ST_HALTED);
    end

    assign bus.mem_addr = (state_q == ST_FETCH) ? bus.pc_in : '0;
    assign bus.mem_rd   = mem_rd_q;
    assign bus.ir_out   = ir_q;
    assign bus.ir_valid = ir_valid_q;
    assign bus.pcinc    = pcinc_q;
    assign bus.pcload   = pcload_q;
    assign bus.bus_out  = bus_out_q;
    assign bus.bus_en   = pcload_q;
    assign bus.halted   = halted_q;

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch sequencer sitting between the 6-bit program counter and the decode/execute logic. Reads the current PC, issues a read to instruction memory, latches the returned 16-bit word into an instruction register, and offers it to decode with a valid/ready handshake. Drives the PC's `pcinc` and `pcload` controls and places jump targets on the internal bus. All state changes on the rising edge; the PC updates on the falling edge of the same clock.

## Interface
- `ADDR_W`, 6: PC / instruction-memory address width.
- `DATA_W`, 16: instruction and bus width.

Ports:
- `clk`  in  1: system clock; all sequencer state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `pc_in`  in  ADDR_W: current PC value.
- `mem_addr`  out  ADDR_W: instruction-memory read address.
- `mem_rd`  out  1: read request.
- `mem_ready`  in  1: read data valid this cycle.
- `mem_data`  in  DATA_W: instruction word.
- `ir_out`  out  DATA_W: latched instruction.
- `ir_valid`  out  1: `ir_out` offered to decode.
- `dec_ready`  in  1: decode accepts `ir_out`.
- `jump_req`  in  1: decode requests a jump, qualified by an accept.
- `jump_target`  in  ADDR_W: jump destination.
- `halt_req`  in  1: decode requests a halt, qualified by an accept.
- `pcinc`  out  1: PC increment strobe.
- `pcload`  out  1: PC load strobe.
- `bus_out`  out  DATA_W: bus drive value, zero-extended `jump_target`.
- `bus_en`  out  1: `bus_out` drives the bus; equals `pcload`.
- `halted`  out  1: sequencer stopped.

## Operation
- States:
  - FETCH: `mem_rd`=1 and `mem_addr`=`pc_in`. On `mem_ready`, `ir_out`<=`mem_data`, `pcinc` pulses one cycle, and the state goes to HOLD. Without `mem_ready` it stays in FETCH with the request held.
  - HOLD: `ir_valid`=1. An accept (`dec_ready`=1) resolves by priority:
    - `halt_req` -> HALTED.
    - `jump_req` -> JUMP.
    - otherwise -> FETCH.
  - JUMP: one cycle. `pcload`=1, `bus_en`=1, `bus_out`={10'b0, `jump_target` registered at accept}; next state FETCH.
  - HALTED: all strobes 0 and `halted`=1. The only exit is reset.
- `halt_req` and `jump_req` are ignored when there is no accept. `halt_req` beats `jump_req` when both are set.
- `ir_out` holds its value until the next `mem_ready` capture.
- Wrap-around: the PC rolls 63->0 on its own; the sequencer simply fetches whatever `pc_in` shows.
- `pcinc` and `pcload` are never asserted in the same cycle.
- Reset (including mid-fetch):
  - State -> FETCH.
  - `ir_out`=0, `ir_valid`=0, `mem_rd`=0, `pcinc`=0, `pcload`=0, `bus_en`=0, `bus_out`=0, `halted`=0.
  - `mem_rd` asserts on the first rising edge after `rst_n` deasserts.
  - A `mem_ready` arriving during reset is discarded.

## Timing
- Outputs are registered, except that `mem_addr` follows `pc_in` combinationally while in FETCH.
- Fetch latency: data is captured on the edge where `mem_ready`=1. `ir_valid` rises in the next cycle, together with the `pcinc` pulse.
- The PC increments on the falling edge mid-cycle, so `pc_in` is stable at the next rising edge.
- Best-case throughput with zero-wait memory and decode always ready: one instruction every 2 cycles (FETCH, HOLD).
- Jump cost: accept edge -> JUMP cycle, during which the PC loads on its falling edge -> FETCH uses the new PC. Total: 3 cycles per jumped instruction.
- `mem_ready` seen outside FETCH is ignored.

## Structure
- Shared package (`cpu_pkg`) holds:
  - the state enum (FETCH, HOLD, JUMP, HALTED);
  - `ADDR_W` and `DATA_W` defaults;
  - the bus zero-extend width constant.
- Single module; no sub-module is needed.
- The instruction register is an inline register in this module, not a separate block.

## Test plan
- Reset release, memory returns 16'hA5A5 with zero wait at PC=0 -> `mem_rd`=1 first cycle; `ir_out`=A5A5 and `ir_valid`=1 next cycle; one `pcinc` pulse; next fetch at `mem_addr`=1.
- Memory ready delayed 3 cycles -> `mem_rd` held 4 cycles with `mem_addr` constant; exactly one `pcinc`.
- HOLD with `dec_ready`=0 for 5 cycles, and `jump_req` toggling -> `ir_valid` stays 1, no strobes, no state change.
- Accept with `jump_req`=1, `jump_target`=6'd42 -> next cycle `pcload`=1 and `bus_out`=16'h002A; following fetch at `mem_addr`=42; no `pcinc` during the jump.
- Accept with `halt_req`=1 and `jump_req`=1 -> HALTED; `halted`=1; no `pcload`; no further `mem_rd` until `rst_n` pulses low.
- PC at 63, normal fetch -> `pcinc` pulses; next `mem_addr`=0. Assert `rst_n`=0 mid-FETCH -> `mem_rd` drops immediately and all outputs take their reset values.
